axi_rd_scheduler: RTL and testbench
===================================

# axi_rd_scheduler

Issues AXI read-address bursts from DDR on behalf of three frame-read channels (ch0..ch2). The block sits in front of the DDR read-return demux. It sets ARID to a one-hot channel tag, and the return path uses that tag to steer read data into the per-channel output FIFOs. Requests are granted round-robin and gated by the downstream FIFO fill flags and by a cap on outstanding bursts, so returning data never overruns the shared DDR-side FIFO or a channel FIFO.

## Interface
- ADDR_WIDTH, 28, AXI byte-address width
- DDR_DWIDTH, 256, AXI data width in bits
- AXI_RD_LEN, 16, beats per burst; BURST_BYTES = AXI_RD_LEN*DDR_DWIDTH/8 (512 at defaults)
- MAX_OUTSTANDING, 4, maximum bursts in flight; range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  3  per-channel one-cycle pulse; bit i restarts channel i
- base_addr  in  3*ADDR_WIDTH  channel i start address at [i*ADDR_WIDTH +: ADDR_WIDTH]; must be BURST_BYTES-aligned
- frame_bursts  in  48  channel i burst count at [i*16 +: 16]
- rd_fifo_full  in  3  channel FIFO above threshold; bit i blocks channel i
- ddr_fifo_full  in  1  shared DDR-side FIFO above threshold; blocks all channels
- axi_araddr  out  ADDR_WIDTH  burst address
- axi_arid  out  4  {1'b0, one-hot channel}
- axi_arlen  out  8  constant AXI_RD_LEN-1
- axi_arvalid  out  1  address valid
- axi_arready  in  1  address accepted
- axi_rid  in  4  read-data ID
- axi_rvalid  in  1  read-data valid
- axi_rlast  in  1  last beat of burst
- busy  out  3  channel i has bursts still to issue
- frame_done  out  3  one-cycle pulse after channel i issues its final burst

## Operation
- Per-channel state:
  - `active`: equals busy[i].
  - `remaining`: 16-bit count of bursts still to issue.
  - `cur_addr`: next burst address, ADDR_WIDTH bits.
  - `restart_pend`: pending restart flag.
- frame_start[i]:
  - Sets restart_pend[i]. A pulse that arrives while restart_pend[i] is already set has no further effect.
  - Pending restarts are applied only while the FSM is in IDLE. Applying loads cur_addr from base_addr, loads remaining from frame_bursts, sets active = (frame_bursts != 0), and clears restart_pend.
  - When frame_bursts == 0, active stays 0 and frame_done[i] pulses in the next cycle.
  - A channel whose restart is applied in a given cycle is not eligible in that cycle.
- Eligibility of channel i: active & ~restart_pend & ~rd_fifo_full[i] & ~ddr_fifo_full & (outstanding < MAX_OUTSTANDING).
- FSM with two states:
  - IDLE: if any channel is eligible, register the round-robin winner (search starts at last_grant+1 mod 3), drive AR fields from that channel, set arvalid = 1, and go to REQ.
  - REQ: hold arvalid and all AR fields stable until arready. On the handshake:
    - arvalid goes to 0 and the FSM returns to IDLE.
    - cur_addr += BURST_BYTES, wrapping modulo 2^ADDR_WIDTH.
    - remaining is decremented. If it reaches 0, active clears and frame_done pulses in the next cycle.
    - last_grant is updated to the granted channel.
- Full flags are sampled only in IDLE. An AR that has already been presented is never withdrawn.
- Outstanding counter (4 bits):
  - +1 on an AR handshake.
  - -1 on axi_rvalid & axi_rlast & ~axi_rid[3].
  - Both events in the same cycle leave it unchanged.
  - Beats with rid[3] = 1 belong to other masters and are ignored.
  - The counter never underflows: a decrement at 0 is ignored.

## Timing
- Reset values:
  - Outputs: arvalid = 0, araddr = 0, arid = 0, busy = 0, frame_done = 0.
  - Internal: FSM = IDLE, outstanding = 0, last_grant = 2 (so ch0 has first priority), all remaining/cur_addr/restart_pend cleared.
- rst asserted during REQ drops arvalid on the next edge and abandons the burst. The bench must not rely on that burst's data.
- frame_start at edge t, with the FSM in IDLE:
  - Restart is applied at t+1.
  - Channel is eligible at t+2.
  - arvalid is high from t+3.
- With arready tied high, the maximum AR rate is one handshake every 2 cycles.
- frame_done is registered: it is high for exactly 1 cycle, one cycle after the final handshake.
- axi_arlen is constant and is unaffected by rst.

## Test plan
- Single frame: rst; frame_start = 001, base0 = 0x1000, bursts0 = 3, arready = 1, no backpressure. Required: ARs at 0x1000, 0x1200, 0x1400, all with arid 0001 and arlen 15; busy[0] falls after the third handshake; frame_done[0] pulses once.
- Round-robin:
  - Stimulus: all three channels started with 4 bursts each; rlast returned promptly.
  - Required: arid sequence 0001, 0010, 0100 repeated 4 times; three frame_done pulses.
- Backpressure:
  - Stimulus: rd_fifo_full = 010 held.
  - Required: no AR carries arid 0010; ch0 and ch2 alternate.
  - Stimulus: ddr_fifo_full = 1.
  - Required: arvalid stays 0 from the next IDLE onward.
- Outstanding limit:
  - Stimulus: no rlast returned.
  - Required: exactly 4 ARs, then stall.
  - Stimulus: one rvalid & rlast with rid = 1001.
  - Required: still stalled.
  - Stimulus: one rvalid & rlast with rid = 0001.
  - Required: exactly one more AR.
- AR stability:
  - Stimulus: arready held low for 5 cycles while rd_fifo_full toggles.
  - Required: arvalid, araddr and arid remain constant until the handshake.
- Restart and reset:
  - Stimulus: frame_start[0] after 2 of 5 bursts.
  - Required: the next ch0 AR is at base0, and the frame completes 5 bursts from there.
  - Stimulus: frame_start with bursts = 0.
  - Required: frame_done pulses and no AR is issued.
  - Stimulus: rst during REQ.
  - Required: arvalid is 0 on the next cycle and all outputs are at their reset values.

Source files
------------

// File: rtl/axi_rd_scheduler.sv
// Round-robin AXI read-address scheduler for three frame-read channels; AR issue 3 cycles after frame_start, then up to one AR every 2 cycles.
// Grants are gated by the channel and DDR FIFO full flags and an outstanding-burst cap; a presented AR is held until arready.
module axi_rd_scheduler #(
  parameter int ADDR_WIDTH      = 28,
  parameter int DDR_DWIDTH      = 256,
  parameter int AXI_RD_LEN      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              frame_start,
  input  logic [3*ADDR_WIDTH-1:0] base_addr,
  input  logic [47:0]             frame_bursts,
  input  logic [2:0]              rd_fifo_full,
  input  logic                    ddr_fifo_full,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]              axi_arid,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [3:0]              axi_rid,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic [2:0]              busy,
  output logic [2:0]              frame_done
);

  localparam int BURST_BYTES = AXI_RD_LEN * DDR_DWIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr [3];
  logic [15:0]           remaining [3];
  logic [2:0]            active;
  logic [2:0]            restart_pend;
  logic [1:0]            last_grant;
  logic [1:0]            grant_ch;
  logic [3:0]            outstanding;

  logic [2:0] elig;
  logic [2:0] apply;
  logic [2:0] idx;
  logic [1:0] win_ch;
  logic       win_vld;
  logic       hs;
  logic       dec;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    apply     = '0;
    hs        = 1'b0;
    elig      = '0;
    win_vld   = 1'b0;
    win_ch    = 2'd0;
    idx       = 3'd0;
    dec       = axi_rvalid & axi_rlast & ~axi_rid[3] & (outstanding != 4'd0);
    for (int i = 0; i < 3; i++)
      elig[i] = active[i] & ~restart_pend[i] & ~rd_fifo_full[i] & ~ddr_fifo_full & (outstanding < MAX_OUT);
    // walk lowest priority first so the highest-priority eligible channel is the final assignment
    for (int k = 2; k >= 0; k--) begin
      idx = {1'b0, last_grant} + 3'd1 + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (elig[idx[1:0]]) begin
        win_vld = 1'b1;
        win_ch  = idx[1:0];
      end
    end
    case (state)
      IDLE: begin
        apply = restart_pend;
        if (win_vld) state_nxt = REQ;
      end
      REQ: begin
        hs = axi_arready;
        if (axi_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cur_addr[i]  <= '0;
        remaining[i] <= '0;
      end
      active       <= '0;
      restart_pend <= '0;
      frame_done   <= '0;
      last_grant   <= 2'd2;
      grant_ch     <= 2'd0;
      outstanding  <= '0;
      axi_araddr   <= '0;
      axi_arid     <= '0;
    end else begin
      frame_done <= '0;
      for (int i = 0; i < 3; i++) begin
        if (apply[i]) begin
          cur_addr[i]   <= base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          remaining[i]  <= frame_bursts[i*16 +: 16];
          active[i]     <= (frame_bursts[i*16 +: 16] != 16'd0);
          frame_done[i] <= (frame_bursts[i*16 +: 16] == 16'd0);
        end else if (hs && grant_ch == 2'(i)) begin
          cur_addr[i]  <= cur_addr[i] + BURST_INC;
          remaining[i] <= remaining[i] - 16'd1;
          if (remaining[i] == 16'd1) begin
            active[i]     <= 1'b0;
            frame_done[i] <= 1'b1;
          end
        end
        // a pulse landing while a restart is pending (or being applied) is absorbed
        restart_pend[i] <= apply[i] ? 1'b0 : (restart_pend[i] | frame_start[i]);
      end
      if (state == IDLE && win_vld) begin
        grant_ch   <= win_ch;
        axi_araddr <= cur_addr[win_ch];
        axi_arid   <= {1'b0, 3'b001 << win_ch};
      end
      if (hs) last_grant <= grant_ch;
      if (hs && !dec)      outstanding <= outstanding + 4'd1;
      else if (!hs && dec) outstanding <= outstanding - 4'd1;
    end
  end

  assign axi_arvalid = (state == REQ);
  assign axi_arlen   = 8'(AXI_RD_LEN - 1);
  assign busy        = active;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Directed bench for axi_rd_scheduler: AR monitor, rlast responder and one task per scenario.
module tb_axi_rd_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  frame_start;
  logic [83:0] base_addr;
  logic [47:0] frame_bursts;
  logic [2:0]  rd_fifo_full;
  logic        ddr_fifo_full;
  logic [27:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic        axi_rvalid;
  logic        axi_rlast;
  logic [2:0]  busy;
  logic [2:0]  frame_done;

  int checks = 0;
  int errors = 0;

  logic [27:0] hs_addr [0:255];
  logic [3:0]  hs_id   [0:255];
  int hs_cnt = 0;
  int fd_cnt [3] = '{0, 0, 0};
  int resp_cnt = 0;
  int man_push = 0;
  int man_pop = 0;
  logic [3:0] man_id = 4'd0;
  bit auto_resp = 1'b0;

  axi_rd_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .base_addr(base_addr),
    .frame_bursts(frame_bursts), .rd_fifo_full(rd_fifo_full), .ddr_fifo_full(ddr_fifo_full),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rid(axi_rid),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && axi_arvalid && axi_arready && hs_cnt < 256) begin
      hs_addr[hs_cnt] = axi_araddr;
      hs_id[hs_cnt]   = axi_arid;
      hs_cnt++;
    end
    for (int i = 0; i < 3; i++)
      if (frame_done[i]) fd_cnt[i]++;
  end

  // one rlast beat per cycle: queued manual beats first, then one per recorded AR when enabled
  always @(posedge clk) begin
    #1;
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rid    = 4'd0;
    if (rst) begin
      resp_cnt = hs_cnt;
    end else if (man_pop != man_push) begin
      axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = man_id;
      man_pop++;
    end else if (auto_resp && resp_cnt < hs_cnt) begin
      axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = hs_id[resp_cnt];
      resp_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = '0;
    rd_fifo_full = '0;
    ddr_fifo_full = 1'b0;
    axi_arready = 1'b1;
    auto_resp = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [27:0] base, input logic [15:0] bursts);
    base_addr[ch*28 +: 28]  = base;
    frame_bursts[ch*16 +: 16] = bursts;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    frame_start = m;
    tick(1);
    frame_start = '0;
  endtask

  task automatic wait_hs(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (hs_cnt >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1);
    checks++;
    if (axi_arlen !== 8'd15) begin errors++; $display("FAIL arlen_in_reset got %0d want 15", axi_arlen); end
    do_reset();
    checks++;
    if (axi_arvalid !== 1'b0 || axi_araddr !== 28'd0 || axi_arid !== 4'd0) begin
      errors++; $display("FAIL reset_ar got v=%0b a=%h id=%b want 0/0/0", axi_arvalid, axi_araddr, axi_arid);
    end
    checks++;
    if (busy !== 3'b000 || frame_done !== 3'b000) begin
      errors++; $display("FAIL reset_status got busy=%b done=%b want 000/000", busy, frame_done);
    end
    checks++;
    if (axi_arlen !== 8'd15) begin errors++; $display("FAIL arlen got %0d want 15", axi_arlen); end
  endtask

  task automatic test_single_frame();
    int h0, f0;
    do_reset();
    set_ch(0, 28'h1000, 16'd3);
    h0 = hs_cnt; f0 = fd_cnt[0];
    pulse_start(3'b001);
    tick(1);
    checks++;
    if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL single_early_arvalid got %0b want 0", axi_arvalid); end
    tick(1);
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 28'h1000 || axi_arid !== 4'b0001 || busy !== 3'b001) begin
      errors++; $display("FAIL single_first_ar got v=%0b a=%h id=%b busy=%b want 1/1000/0001/001",
                         axi_arvalid, axi_araddr, axi_arid, busy);
    end
    tick(5);
    checks++;
    if (hs_cnt - h0 != 3 || busy !== 3'b000 || frame_done !== 3'b001) begin
      errors++; $display("FAIL single_end got hs=%0d busy=%b done=%b want 3/000/001", hs_cnt - h0, busy, frame_done);
    end
    tick(1);
    checks++;
    if (frame_done !== 3'b000) begin errors++; $display("FAIL single_done_width got %b want 000", frame_done); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (hs_addr[h0+j] !== 28'h1000 + 28'(j * 512) || hs_id[h0+j] !== 4'b0001) begin
        errors++; $display("FAIL single_ar%0d got a=%h id=%b want a=%h id=0001", j, hs_addr[h0+j], hs_id[h0+j],
                           28'h1000 + 28'(j * 512));
      end
    end
    tick(5);
    checks++;
    if (fd_cnt[0] - f0 != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", fd_cnt[0] - f0); end
  endtask

  task automatic test_round_robin();
    int h0;
    bit ok;
    logic [27:0] bases [3];
    int f0 [3];
    bases[0] = 28'h0000000; bases[1] = 28'h0010000; bases[2] = 28'h0020000;
    do_reset();
    auto_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ch(i, bases[i], 16'd4);
      f0[i] = fd_cnt[i];
    end
    h0 = hs_cnt;
    pulse_start(3'b111);
    wait_hs(h0 + 12, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout got %0d ARs want 12", hs_cnt - h0); end
    for (int n = 0; n < 12; n++) begin
      logic [3:0]  eid;
      logic [27:0] ea;
      eid = 4'b0001 << (n % 3);
      ea  = bases[n % 3] + 28'((n / 3) * 512);
      checks++;
      if (hs_id[h0+n] !== eid || hs_addr[h0+n] !== ea) begin
        errors++; $display("FAIL rr_ar%0d got id=%b a=%h want id=%b a=%h", n, hs_id[h0+n], hs_addr[h0+n], eid, ea);
      end
    end
    tick(5);
    checks++;
    if (fd_cnt[0] - f0[0] != 1 || fd_cnt[1] - f0[1] != 1 || fd_cnt[2] - f0[2] != 1 || hs_cnt - h0 != 12) begin
      errors++; $display("FAIL rr_done got %0d/%0d/%0d hs=%0d want 1/1/1 hs=12", fd_cnt[0] - f0[0],
                         fd_cnt[1] - f0[1], fd_cnt[2] - f0[2], hs_cnt - h0);
    end
  endtask

  task automatic test_backpressure();
    int h0;
    bit ok;
    logic [3:0] exp_ids [9];
    exp_ids = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
    do_reset();
    auto_resp = 1'b1;
    for (int i = 0; i < 3; i++) set_ch(i, 28'h100000 * 28'(i + 1), 16'd3);
    rd_fifo_full = 3'b010;
    h0 = hs_cnt;
    pulse_start(3'b111);
    wait_hs(h0 + 6, 60, ok);
    tick(10);
    checks++;
    if (!ok || hs_cnt - h0 != 6 || busy !== 3'b010) begin
      errors++; $display("FAIL bp_blocked got hs=%0d busy=%b want 6/010", hs_cnt - h0, busy);
    end
    rd_fifo_full = 3'b000;
    wait_hs(h0 + 9, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_release_timeout got %0d want 9", hs_cnt - h0); end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (hs_id[h0+n] !== exp_ids[n]) begin
        errors++; $display("FAIL bp_id%0d got %b want %b", n, hs_id[h0+n], exp_ids[n]);
      end
    end
    do_reset();
    auto_resp = 1'b1;
    set_ch(0, 28'h0, 16'd4);
    ddr_fifo_full = 1'b1;
    h0 = hs_cnt;
    pulse_start(3'b001);
    tick(20);
    checks++;
    if (hs_cnt != h0 || axi_arvalid !== 1'b0 || busy !== 3'b001) begin
      errors++; $display("FAIL ddr_full got hs=%0d v=%0b busy=%b want 0/0/001", hs_cnt - h0, axi_arvalid, busy);
    end
    ddr_fifo_full = 1'b0;
    wait_hs(h0 + 4, 40, ok);
    checks++;
    if (!ok || hs_addr[h0+3] !== 28'h600) begin
      errors++; $display("FAIL ddr_release got hs=%0d last=%h want 4/600", hs_cnt - h0, hs_addr[h0+3]);
    end
  endtask

  task automatic test_outstanding();
    int h0;
    bit ok;
    do_reset();
    auto_resp = 1'b0;
    man_id = 4'b0001; man_push++;
    tick(2);
    man_id = 4'b0001; man_push++;
    tick(2);
    set_ch(0, 28'h0, 16'd8);
    h0 = hs_cnt;
    pulse_start(3'b001);
    wait_hs(h0 + 4, 40, ok);
    tick(20);
    checks++;
    if (!ok || hs_cnt - h0 != 4 || axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL out_cap got hs=%0d v=%0b want 4/0", hs_cnt - h0, axi_arvalid);
    end
    man_id = 4'b1001; man_push++;
    tick(10);
    checks++;
    if (hs_cnt - h0 != 4) begin errors++; $display("FAIL out_foreign_rid got hs=%0d want 4", hs_cnt - h0); end
    man_id = 4'b0001; man_push++;
    tick(15);
    checks++;
    if (hs_cnt - h0 != 5 || hs_addr[h0+4] !== 28'h800) begin
      errors++; $display("FAIL out_one_more got hs=%0d a=%h want 5/800", hs_cnt - h0, hs_addr[h0+4]);
    end
  endtask

  task automatic test_ar_stability();
    int h0, n;
    bit ok;
    do_reset();
    auto_resp = 1'b1;
    axi_arready = 1'b0;
    set_ch(0, 28'h3000, 16'd2);
    h0 = hs_cnt;
    pulse_start(3'b001);
    n = 0;
    while (axi_arvalid !== 1'b1 && n < 10) begin tick(1); n++; end
    for (int c = 0; c < 5; c++) begin
      rd_fifo_full = {2'b00, ~c[0]};
      tick(1);
      checks++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== 28'h3000 || axi_arid !== 4'b0001) begin
        errors++; $display("FAIL stable_c%0d got v=%0b a=%h id=%b want 1/3000/0001", c, axi_arvalid, axi_araddr, axi_arid);
      end
    end
    rd_fifo_full = 3'b000;
    axi_arready = 1'b1;
    tick(1);
    checks++;
    if (hs_cnt - h0 != 1 || hs_addr[h0] !== 28'h3000) begin
      errors++; $display("FAIL stable_hs got hs=%0d a=%h want 1/3000", hs_cnt - h0, hs_addr[h0]);
    end
    wait_hs(h0 + 2, 20, ok);
    checks++;
    if (!ok || hs_addr[h0+1] !== 28'h3200) begin
      errors++; $display("FAIL stable_second got a=%h want 3200", hs_addr[h0+1]);
    end
  endtask

  task automatic test_restart_and_reset();
    int h0, f0;
    bit ok;
    do_reset();
    auto_resp = 1'b1;
    set_ch(0, 28'h4000, 16'd5);
    h0 = hs_cnt; f0 = fd_cnt[0];
    pulse_start(3'b001);
    wait_hs(h0 + 1, 20, ok);
    tick(1);
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 28'h4200) begin
      errors++; $display("FAIL restart_second_ar got v=%0b a=%h want 1/4200", axi_arvalid, axi_araddr);
    end
    pulse_start(3'b001);
    wait_hs(h0 + 7, 60, ok);
    tick(10);
    checks++;
    if (!ok || hs_cnt - h0 != 7 || busy !== 3'b000 || fd_cnt[0] - f0 != 1) begin
      errors++; $display("FAIL restart_total got hs=%0d busy=%b done=%0d want 7/000/1", hs_cnt - h0, busy, fd_cnt[0] - f0);
    end
    checks++;
    if (hs_addr[h0+2] !== 28'h4000 || hs_addr[h0+6] !== 28'h4800) begin
      errors++; $display("FAIL restart_addr got %h..%h want 4000..4800", hs_addr[h0+2], hs_addr[h0+6]);
    end

    do_reset();
    set_ch(0, 28'h8000, 16'd0);
    h0 = hs_cnt;
    pulse_start(3'b001);
    tick(1);
    checks++;
    if (frame_done !== 3'b001 || busy !== 3'b000) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b want 001/000", frame_done, busy);
    end
    tick(1);
    checks++;
    if (frame_done !== 3'b000) begin errors++; $display("FAIL zero_done_width got %b want 000", frame_done); end
    tick(10);
    checks++;
    if (hs_cnt != h0 || axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL zero_no_ar got hs=%0d v=%0b want 0/0", hs_cnt - h0, axi_arvalid);
    end

    do_reset();
    axi_arready = 1'b0;
    set_ch(1, 28'h5000, 16'd2);
    pulse_start(3'b010);
    tick(2);
    checks++;
    if (axi_arvalid !== 1'b1 || axi_arid !== 4'b0010 || axi_araddr !== 28'h5000) begin
      errors++; $display("FAIL rst_req_pre got v=%0b id=%b a=%h want 1/0010/5000", axi_arvalid, axi_arid, axi_araddr);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (axi_arvalid !== 1'b0 || axi_araddr !== 28'd0 || axi_arid !== 4'd0 || busy !== 3'b000 ||
        frame_done !== 3'b000 || axi_arlen !== 8'd15) begin
      errors++; $display("FAIL rst_req_post got v=%0b a=%h id=%b busy=%b done=%b len=%0d want 0/0/0/000/000/15",
                         axi_arvalid, axi_araddr, axi_arid, busy, frame_done, axi_arlen);
    end
    rst = 1'b0;
    axi_arready = 1'b1;
    h0 = hs_cnt;
    tick(10);
    checks++;
    if (hs_cnt != h0 || axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL rst_abandon got hs=%0d v=%0b want 0/0", hs_cnt - h0, axi_arvalid);
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = '0;
    base_addr = '0;
    frame_bursts = '0;
    rd_fifo_full = '0;
    ddr_fifo_full = 1'b0;
    axi_arready = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_outstanding();
    test_ar_stability();
    test_restart_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
